bcd_countup_timer: RTL

Four-digit BCD elapsed-time counter (MM:SS, 00:00 to 99:59) that counts up from zero toward a loaded target and flags completion. It is the count-up counterpart of the existing mod-10 countdown digit counters: same load/clear/enable style, opposite direction. It sits in the timer datapath beside the countdown chain, feeding the display decoders, and its `done` flag drives the control FSM.

---
 rtl/bcd_countup_timer_if.sv | 23 ++
 rtl/bcd_countup_timer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/bcd_countup_timer_if.sv
// Control/status bundle for the BCD count-up timer.
// master drives load/start/stop/target and observes the count and flags; slave is the timer.
interface bcd_countup_timer_if;
  logic        loadn;
  logic        start;
  logic        stop;
  logic [15:0] TGT_in;
  logic [15:0] CNT;
  logic        running;
  logic        done;
  logic        tc;
  logic        tgt_err;

  modport master (
    output loadn, start, stop, TGT_in,
    input  CNT, running, done, tc, tgt_err
  );

  modport slave (
    input  loadn, start, stop, TGT_in,
    output CNT, running, done, tc, tgt_err
  );
endinterface

// File: rtl/bcd_countup_timer.sv
// Four-digit MM:SS BCD elapsed-time counter that counts up to a loaded target.
// A prescaler turns clk into one-second ticks; done/tc flag arrival at the target.
module bcd_countup_timer #(
  parameter int unsigned TICK_DIV = 100
) (
  input  logic                 clk,
  input  logic                 clrn,
  bcd_countup_timer_if.slave   bus_io
);

  localparam int unsigned PscW = $clog2(TICK_DIV);
  localparam logic [PscW-1:0] PscMax = PscW'(TICK_DIV - 1);
  localparam logic [PscW-1:0] PscOne = PscW'(1);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [15:0]     tgt_q, tgt_d;
  logic [PscW-1:0] psc_q, psc_d;
  logic            tc_q, tc_d;
  logic            tgt_err_q, tgt_err_d;
  logic [15:0]     cnt_inc;

  // Digit order {min_tens, min_ones, sec_tens, sec_ones}; 99:59 wraps to 00:00.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [3:0] d3, d2, d1, d0;
    {d3, d2, d1, d0} = v;
    if (d0 == 4'd9) begin
      d0 = 4'd0;
      if (d1 == 4'd5) begin
        d1 = 4'd0;
        if (d2 == 4'd9) begin
          d2 = 4'd0;
          d3 = (d3 == 4'd9) ? 4'd0 : d3 + 4'd1;
        end else begin
          d2 = d2 + 4'd1;
        end
      end else begin
        d1 = d1 + 4'd1;
      end
    end else begin
      d0 = d0 + 4'd1;
    end
    return {d3, d2, d1, d0};
  endfunction

  function automatic logic bcd_bad(input logic [15:0] v);
    return (v[15:12] > 4'd9) || (v[11:8] > 4'd9) || (v[7:4] > 4'd5) || (v[3:0] > 4'd9);
  endfunction

  assign cnt_inc = bcd_inc(cnt_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tgt_d     = tgt_q;
    psc_d     = psc_q;
    tc_d      = 1'b0;
    tgt_err_d = tgt_err_q;

    if (!bus_io.loadn) begin
      tgt_d     = bus_io.TGT_in;
      tgt_err_d = bcd_bad(bus_io.TGT_in);
      cnt_d     = '0;
      psc_d     = '0;
      state_d   = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus_io.start && !tgt_err_q) begin
            // A zero target is already reached: finish without waiting for a tick.
            if (tgt_q == 16'h0000) begin
              state_d = StDone;
              tc_d    = 1'b1;
            end else begin
              state_d = StRun;
            end
          end
        end
        StRun: begin
          if (bus_io.stop) begin
            state_d = StPause;
          end else if (psc_q == PscMax) begin
            psc_d = '0;
            cnt_d = cnt_inc;
            if (cnt_inc == tgt_q) begin
              state_d = StDone;
              tc_d    = 1'b1;
            end
          end else begin
            psc_d = psc_q + PscOne;
          end
        end
        StPause: begin
          if (bus_io.start && !bus_io.stop && !tgt_err_q) state_d = StRun;
        end
        StDone: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      tgt_q     <= '0;
      psc_q     <= '0;
      tc_q      <= 1'b0;
      tgt_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tgt_q     <= tgt_d;
      psc_q     <= psc_d;
      tc_q      <= tc_d;
      tgt_err_q <= tgt_err_d;
    end
  end

  assign bus_io.CNT     = cnt_q;
  assign bus_io.running = (state_q == StRun);
  assign bus_io.done    = (state_q == StDone);
  assign bus_io.tc      = tc_q;
  assign bus_io.tgt_err = tgt_err_q;

endmodule
